// File: rtl/reg_rw_ctrl_if.sv
// Issue/read/write-back bundle between decode, the access controller and the register file.
// master = decode/write-back side, slave = the controller.
interface reg_rw_ctrl_if #(
   parameter int NUM_REGS    = 8,
   parameter int DATA_W      = 8,
   parameter int MAX_PENDING = 4
);
   localparam int ADDR_W = $clog2(NUM_REGS);
   localparam int CNT_W  = $clog2(MAX_PENDING + 1);

   logic                issue_valid;
   logic                issue_ready;
   logic [ADDR_W-1:0]   rd_a_addr;
   logic [ADDR_W-1:0]   rd_b_addr;
   logic                rd_a_en;
   logic                rd_b_en;
   logic [ADDR_W-1:0]   wr_addr;
   logic                wr_en;
   logic                wb_valid;
   logic [ADDR_W-1:0]   wb_addr;
   logic [DATA_W-1:0]   wb_data;
   logic [NUM_REGS-1:0] x_read_a_en;
   logic [NUM_REGS-1:0] x_read_b_en;
   logic                fwd_a;
   logic                fwd_b;
   logic [DATA_W-1:0]   fwd_data;
   logic [NUM_REGS-1:0] x_write_en;
   logic [DATA_W-1:0]   x_wr_data;
   logic [CNT_W-1:0]    pending;
   logic                wb_err;

   modport master (
      output issue_valid, rd_a_addr, rd_b_addr, rd_a_en, rd_b_en, wr_addr, wr_en,
             wb_valid, wb_addr, wb_data,
      input  issue_ready, x_read_a_en, x_read_b_en, fwd_a, fwd_b, fwd_data,
             x_write_en, x_wr_data, pending, wb_err
   );

   modport slave (
      input  issue_valid, rd_a_addr, rd_b_addr, rd_a_en, rd_b_en, wr_addr, wr_en,
             wb_valid, wb_addr, wb_data,
      output issue_ready, x_read_a_en, x_read_b_en, fwd_a, fwd_b, fwd_data,
             x_write_en, x_wr_data, pending, wb_err
   );
endinterface

// File: rtl/reg_rw_ctrl.sv
// Register-file access controller: one-hot read/write decode, busy scoreboard with
// RAW/WAW/depth stalls and same-cycle write-back bypass.
module reg_rw_ctrl #(
   parameter int NUM_REGS    = 8,
   parameter int DATA_W      = 8,
   parameter int MAX_PENDING = 4,
   parameter int ZERO_REG    = 0
) (
   input logic           clk,
   input logic           rst_n,
   reg_rw_ctrl_if.slave  bus
);
   localparam int ADDR_W = $clog2(NUM_REGS);
   localparam int CNT_W  = $clog2(MAX_PENDING + 1);
   localparam logic [CNT_W-1:0]    MAX_CNT = CNT_W'(MAX_PENDING);
   localparam logic [NUM_REGS-1:0] ONE_HOT = NUM_REGS'(1);

   logic [NUM_REGS-1:0] busy, busy_nxt, eb, wb_hot;
   logic [ADDR_W-1:0]   rd_a_addr, rd_b_addr, wr_addr, wb_addr;
   logic [CNT_W-1:0]    pending_q;
   logic                wb_frees, wb_zero, wr_counted, accept;
   logic                fwd_a_hit, fwd_b_hit, stall;

   assign rd_a_addr = bus.rd_a_addr;
   assign rd_b_addr = bus.rd_b_addr;
   assign wr_addr   = bus.wr_addr;
   assign wb_addr   = bus.wb_addr;

   assign wb_hot     = ONE_HOT << wb_addr;
   assign wb_frees   = bus.wb_valid && busy[wb_addr];
   assign wb_zero    = (ZERO_REG != 0) && (wb_addr == '0);
   assign wr_counted = bus.wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
   // A write-back landing this cycle resolves its hazard for the issuing instruction.
   assign eb         = bus.wb_valid ? (busy & ~wb_hot) : busy;

   assign stall = (bus.rd_a_en && eb[rd_a_addr])
               || (bus.rd_b_en && eb[rd_b_addr])
               || (bus.wr_en   && eb[wr_addr])
               || (wr_counted && (pending_q == MAX_CNT) && !wb_frees);

   assign bus.issue_ready = !stall;
   assign accept          = bus.issue_valid && !stall;
   assign bus.pending     = pending_q;

   assign fwd_a_hit = bus.rd_a_en && wb_frees && (rd_a_addr == wb_addr);
   assign fwd_b_hit = bus.rd_b_en && wb_frees && (rd_b_addr == wb_addr);

   always_comb begin
      busy_nxt = busy;
      if (wb_frees)
         busy_nxt[wb_addr] = 1'b0;
      if (accept && wr_counted)
         busy_nxt[wr_addr] = 1'b1;
      if (ZERO_REG != 0)
         busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy            <= '0;
         pending_q       <= '0;
         bus.wb_err      <= 1'b0;
         bus.x_read_a_en <= '0;
         bus.x_read_b_en <= '0;
         bus.fwd_a       <= 1'b0;
         bus.fwd_b       <= 1'b0;
         bus.fwd_data    <= '0;
         bus.x_write_en  <= '0;
         bus.x_wr_data   <= '0;
      end else begin
         busy <= busy_nxt;
         case ({accept && wr_counted, wb_frees})
            2'b10:   pending_q <= pending_q + 1'b1;
            2'b01:   pending_q <= pending_q - 1'b1;
            default: pending_q <= pending_q;
         endcase
         if (bus.wb_valid && !busy[wb_addr] && !wb_zero)
            bus.wb_err <= 1'b1;

         bus.x_read_a_en <= '0;
         bus.x_read_b_en <= '0;
         bus.fwd_a       <= 1'b0;
         bus.fwd_b       <= 1'b0;
         if (accept) begin
            if (bus.rd_a_en && !fwd_a_hit)
               bus.x_read_a_en <= ONE_HOT << rd_a_addr;
            if (bus.rd_b_en && !fwd_b_hit)
               bus.x_read_b_en <= ONE_HOT << rd_b_addr;
            bus.fwd_a <= fwd_a_hit;
            bus.fwd_b <= fwd_b_hit;
            if (fwd_a_hit || fwd_b_hit)
               bus.fwd_data <= bus.wb_data;
         end

         bus.x_write_en <= wb_frees ? wb_hot : '0;
         if (wb_frees)
            bus.x_wr_data <= bus.wb_data;
      end
   end
endmodule

// File: tb/tb_reg_rw_ctrl.sv
// Directed bench for reg_rw_ctrl: default 8-register instance plus a ZERO_REG 16-register one.
module tb_reg_rw_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   reg_rw_ctrl_if #(.NUM_REGS(8), .DATA_W(8), .MAX_PENDING(4)) b ();
   reg_rw_ctrl_if #(.NUM_REGS(16), .DATA_W(8), .MAX_PENDING(4)) z ();

   reg_rw_ctrl #(.NUM_REGS(8), .DATA_W(8), .MAX_PENDING(4), .ZERO_REG(0)) dut (
      .clk(clk), .rst_n(rst_n), .bus(b)
   );
   reg_rw_ctrl #(.NUM_REGS(16), .DATA_W(8), .MAX_PENDING(4), .ZERO_REG(1)) dut_z (
      .clk(clk), .rst_n(rst_n), .bus(z)
   );

   task automatic idle_b();
      b.issue_valid = 0; b.rd_a_en = 0; b.rd_b_en = 0; b.wr_en = 0;
      b.rd_a_addr = 0; b.rd_b_addr = 0; b.wr_addr = 0;
      b.wb_valid = 0; b.wb_addr = 0; b.wb_data = 0;
   endtask

   task automatic idle_z();
      z.issue_valid = 0; z.rd_a_en = 0; z.rd_b_en = 0; z.wr_en = 0;
      z.rd_a_addr = 0; z.rd_b_addr = 0; z.wr_addr = 0;
      z.wb_valid = 0; z.wb_addr = 0; z.wb_data = 0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      idle_b(); idle_z();
      rst_n = 0;
      #12;
      n_checks++; if (b.pending !== 3'd0) begin n_fail++; $display("FAIL reset_pending: got %0d want 0", b.pending); end
      n_checks++; if (b.x_write_en !== 8'h00 || b.x_read_a_en !== 8'h00 || b.x_read_b_en !== 8'h00) begin
         n_fail++; $display("FAIL reset_enables: got w=%h a=%h b=%h want 00", b.x_write_en, b.x_read_a_en, b.x_read_b_en); end
      n_checks++; if ({b.fwd_a, b.fwd_b, b.wb_err} !== 3'b000 || b.fwd_data !== 8'h00 || b.x_wr_data !== 8'h00) begin
         n_fail++; $display("FAIL reset_flags: got fa=%b fb=%b err=%b fd=%h wd=%h want 0", b.fwd_a, b.fwd_b, b.wb_err, b.fwd_data, b.x_wr_data); end
      @(negedge clk); rst_n = 1;
      tick();
      n_checks++; if (b.issue_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %b want 1", b.issue_ready); end
      n_checks++; if (z.issue_ready !== 1'b1 || z.pending !== 3'd0) begin
         n_fail++; $display("FAIL idle_zero_dut: got ready=%b pend=%0d want 1/0", z.issue_ready, z.pending); end
   endtask

   task automatic test_raw();
      @(negedge clk); idle_b(); b.issue_valid = 1; b.wr_en = 1; b.wr_addr = 3; #1;
      n_checks++; if (b.issue_ready !== 1'b1) begin n_fail++; $display("FAIL raw_wr_accept: got %b want 1", b.issue_ready); end
      tick();
      n_checks++; if (b.pending !== 3'd1) begin n_fail++; $display("FAIL raw_pending1: got %0d want 1", b.pending); end
      @(negedge clk); b.wr_en = 0; b.rd_a_en = 1; b.rd_a_addr = 3; #1;
      n_checks++; if (b.issue_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall: got %b want 0", b.issue_ready); end
      tick();
      n_checks++; if (b.x_read_a_en !== 8'h00) begin n_fail++; $display("FAIL raw_no_read: got %h want 00", b.x_read_a_en); end
      @(negedge clk); b.wb_valid = 1; b.wb_addr = 3; b.wb_data = 8'hA5; #1;
      n_checks++; if (b.issue_ready !== 1'b1) begin n_fail++; $display("FAIL raw_wb_ready: got %b want 1", b.issue_ready); end
      tick();
      n_checks++; if (b.fwd_a !== 1'b1 || b.fwd_data !== 8'hA5) begin
         n_fail++; $display("FAIL raw_fwd: got fwd_a=%b data=%h want 1/a5", b.fwd_a, b.fwd_data); end
      n_checks++; if (b.x_read_a_en !== 8'h00 || b.x_write_en !== 8'h08 || b.x_wr_data !== 8'hA5) begin
         n_fail++; $display("FAIL raw_enables: got rd=%h wr=%h wd=%h want 00/08/a5", b.x_read_a_en, b.x_write_en, b.x_wr_data); end
      n_checks++; if (b.pending !== 3'd0) begin n_fail++; $display("FAIL raw_pending0: got %0d want 0", b.pending); end
      @(negedge clk); idle_b();
      tick();
      n_checks++; if (b.fwd_a !== 1'b0 || b.x_write_en !== 8'h00) begin
         n_fail++; $display("FAIL raw_pulse: got fwd_a=%b wr=%h want 0/00", b.fwd_a, b.x_write_en); end
   endtask

   task automatic test_depth();
      for (int r = 1; r <= 4; r++) begin
         @(negedge clk); idle_b(); b.issue_valid = 1; b.wr_en = 1; b.wr_addr = 3'(r); #1;
         n_checks++; if (b.issue_ready !== 1'b1) begin n_fail++; $display("FAIL depth_fill r%0d: got %b want 1", r, b.issue_ready); end
         tick();
      end
      n_checks++; if (b.pending !== 3'd4) begin n_fail++; $display("FAIL depth_full: got %0d want 4", b.pending); end
      @(negedge clk); b.wr_addr = 5; #1;
      n_checks++; if (b.issue_ready !== 1'b0) begin n_fail++; $display("FAIL depth_stall: got %b want 0", b.issue_ready); end
      tick();
      n_checks++; if (b.pending !== 3'd4) begin n_fail++; $display("FAIL depth_hold: got %0d want 4", b.pending); end
      @(negedge clk); b.wb_valid = 1; b.wb_addr = 1; b.wb_data = 8'h11; #1;
      n_checks++; if (b.issue_ready !== 1'b1) begin n_fail++; $display("FAIL depth_wb_ready: got %b want 1", b.issue_ready); end
      tick();
      n_checks++; if (b.pending !== 3'd4 || b.x_write_en !== 8'h02) begin
         n_fail++; $display("FAIL depth_swap: got pend=%0d wr=%h want 4/02", b.pending, b.x_write_en); end
      for (int r = 2; r <= 5; r++) begin
         @(negedge clk); idle_b(); b.wb_valid = 1; b.wb_addr = 3'(r); b.wb_data = 8'(r);
         tick();
      end
      @(negedge clk); idle_b();
      n_checks++; if (b.pending !== 3'd0 || b.wb_err !== 1'b0) begin
         n_fail++; $display("FAIL depth_drain: got pend=%0d err=%b want 0/0", b.pending, b.wb_err); end
   endtask

   task automatic test_waw();
      @(negedge clk); idle_b(); b.issue_valid = 1; b.wr_en = 1; b.wr_addr = 2;
      tick();
      @(negedge clk); #1;
      n_checks++; if (b.issue_ready !== 1'b0) begin n_fail++; $display("FAIL waw_stall: got %b want 0", b.issue_ready); end
      b.wb_valid = 1; b.wb_addr = 2; b.wb_data = 8'h5C; #1;
      n_checks++; if (b.issue_ready !== 1'b1) begin n_fail++; $display("FAIL waw_same_cycle: got %b want 1", b.issue_ready); end
      tick();
      n_checks++; if (b.x_write_en !== 8'h04 || b.x_wr_data !== 8'h5C || b.pending !== 3'd1) begin
         n_fail++; $display("FAIL waw_wb: got wr=%h wd=%h pend=%0d want 04/5c/1", b.x_write_en, b.x_wr_data, b.pending); end
      @(negedge clk); idle_b(); b.issue_valid = 1; b.rd_a_en = 1; b.rd_a_addr = 2; #1;
      n_checks++; if (b.issue_ready !== 1'b0) begin n_fail++; $display("FAIL waw_still_busy: got %b want 0", b.issue_ready); end
      @(negedge clk); idle_b(); b.wb_valid = 1; b.wb_addr = 2;
      tick();
      n_checks++; if (b.pending !== 3'd0) begin n_fail++; $display("FAIL waw_drain: got %0d want 0", b.pending); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk); idle_b(); b.issue_valid = 1;
      b.rd_a_en = 1; b.rd_a_addr = 5; b.rd_b_en = 1; b.rd_b_addr = 7;
      tick();
      n_checks++; if (b.x_read_a_en !== 8'h20 || b.x_read_b_en !== 8'h80) begin
         n_fail++; $display("FAIL b2b_first: got a=%h b=%h want 20/80", b.x_read_a_en, b.x_read_b_en); end
      @(negedge clk); b.rd_a_addr = 0; b.rd_b_addr = 1;
      tick();
      n_checks++; if (b.x_read_a_en !== 8'h01 || b.x_read_b_en !== 8'h02) begin
         n_fail++; $display("FAIL b2b_second: got a=%h b=%h want 01/02", b.x_read_a_en, b.x_read_b_en); end
      @(negedge clk); idle_b(); b.issue_valid = 1; b.wr_en = 1; b.wr_addr = 4;
      tick();
      @(negedge clk); idle_b(); b.issue_valid = 1;
      b.rd_a_en = 1; b.rd_a_addr = 6; b.rd_b_en = 1; b.rd_b_addr = 4;
      b.wb_valid = 1; b.wb_addr = 4; b.wb_data = 8'h3C;
      tick();
      n_checks++; if (b.fwd_b !== 1'b1 || b.fwd_a !== 1'b0 || b.fwd_data !== 8'h3C) begin
         n_fail++; $display("FAIL b2b_fwd_b: got fa=%b fb=%b fd=%h want 0/1/3c", b.fwd_a, b.fwd_b, b.fwd_data); end
      n_checks++; if (b.x_read_a_en !== 8'h40 || b.x_read_b_en !== 8'h00) begin
         n_fail++; $display("FAIL b2b_fwd_rd: got a=%h b=%h want 40/00", b.x_read_a_en, b.x_read_b_en); end
      @(negedge clk); idle_b();
   endtask

   task automatic test_spurious();
      @(negedge clk); idle_b(); b.wb_valid = 1; b.wb_addr = 6; b.wb_data = 8'hEE;
      tick();
      n_checks++; if (b.x_write_en !== 8'h00 || b.wb_err !== 1'b1 || b.pending !== 3'd0) begin
         n_fail++; $display("FAIL spur_wb: got wr=%h err=%b pend=%0d want 00/1/0", b.x_write_en, b.wb_err, b.pending); end
      @(negedge clk); idle_b();
      tick(); tick();
      n_checks++; if (b.wb_err !== 1'b1) begin n_fail++; $display("FAIL spur_sticky: got %b want 1", b.wb_err); end
   endtask

   task automatic test_zero_reg();
      @(negedge clk); idle_z(); z.issue_valid = 1; z.wr_en = 1; z.wr_addr = 0; #1;
      n_checks++; if (z.issue_ready !== 1'b1) begin n_fail++; $display("FAIL zero_wr_ready: got %b want 1", z.issue_ready); end
      tick();
      n_checks++; if (z.pending !== 3'd0) begin n_fail++; $display("FAIL zero_pending: got %0d want 0", z.pending); end
      @(negedge clk); z.wr_en = 0; z.rd_a_en = 1; z.rd_a_addr = 0; #1;
      n_checks++; if (z.issue_ready !== 1'b1) begin n_fail++; $display("FAIL zero_rd_ready: got %b want 1", z.issue_ready); end
      tick();
      n_checks++; if (z.x_read_a_en !== 16'h0001) begin n_fail++; $display("FAIL zero_rd_en: got %h want 0001", z.x_read_a_en); end
      @(negedge clk); idle_z(); z.wb_valid = 1; z.wb_addr = 0; z.wb_data = 8'h99;
      tick();
      n_checks++; if (z.x_write_en !== 16'h0000 || z.wb_err !== 1'b0) begin
         n_fail++; $display("FAIL zero_wb: got wr=%h err=%b want 0000/0", z.x_write_en, z.wb_err); end
      @(negedge clk); idle_z();
   endtask

   task automatic test_reset_mid();
      @(negedge clk); idle_b(); b.issue_valid = 1; b.wr_en = 1; b.wr_addr = 7;
      tick();
      n_checks++; if (b.pending !== 3'd1) begin n_fail++; $display("FAIL mid_pending1: got %0d want 1", b.pending); end
      @(negedge clk); idle_b(); #2; rst_n = 0; #1;
      n_checks++; if (b.pending !== 3'd0 || b.wb_err !== 1'b0) begin
         n_fail++; $display("FAIL mid_async: got pend=%0d err=%b want 0/0", b.pending, b.wb_err); end
      @(negedge clk); rst_n = 1;
      @(negedge clk); b.wb_valid = 1; b.wb_addr = 7; b.wb_data = 8'h77;
      tick();
      n_checks++; if (b.x_write_en !== 8'h00 || b.wb_err !== 1'b1) begin
         n_fail++; $display("FAIL mid_late_wb: got wr=%h err=%b want 00/1", b.x_write_en, b.wb_err); end
      @(negedge clk); idle_b();
   endtask

   initial begin
      test_reset();
      test_raw();
      test_depth();
      test_waw();
      test_back_to_back();
      test_spurious();
      test_zero_reg();
      test_reset_mid();
      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
